// File: rtl/dma_word_copy.sv
//------------------------------------------------------------------------------
// dma_word_copy
//
// Word-granular memory-to-memory copy engine. Acts as the initiator on a
// data-memory-style port: every word is read from the source pointer into a
// one-word buffer, then written to the destination pointer. Only one bus
// request is ever outstanding, and read and write never overlap.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-low reset (0 = reset)
//   start        single-cycle job strobe, accepted only while idle
//   abort        early-termination request, level or pulse
//   src_addr     source byte address, latched on accepted start
//   dst_addr     destination byte address, latched on accepted start
//   len_words    number of 32-bit words to copy, latched on accepted start
//   busy         high from the cycle after start through the done cycle
//   done         single-cycle completion pulse
//   err          job ended by misalignment, bus fault or abort; held until
//                the next accepted start
//   words_done   words fully written in the current / last job
//   m_addr       request byte address
//   m_wdata      write data
//   m_size       access size, WORD_SIZE while a request is active, else 0
//   m_ren        read request
//   m_wen        write request
//   m_rdata      read data, valid in the m_ready cycle of a read
//   m_ready      slave completes the current request this cycle
//   m_fault      slave reports an error for the current request
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for start, no bus traffic
//   ST_READ  | read request at src_ptr held until ready/fault
//   ST_WRITE | write request of the buffered word at dst_ptr
//   ST_FIN   | one-cycle done pulse, busy still high
//------------------------------------------------------------------------------
module dma_word_copy #(
   parameter int         LEN_W     = 16,
   parameter logic [1:0] WORD_SIZE = 2'b10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] words_done,
   output logic [31:0]      m_addr,
   output logic [31:0]      m_wdata,
   output logic [1:0]       m_size,
   output logic             m_ren,
   output logic             m_wen,
   input  logic [31:0]      m_rdata,
   input  logic             m_ready,
   input  logic             m_fault
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      src_ptr_q, src_ptr_d;
   logic [31:0]      dst_ptr_q, dst_ptr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] words_done_q, words_done_d;
   logic [31:0]      buf_q, buf_d;
   logic             err_q, err_d;
   logic             abort_q, abort_d;

   logic             abort_eff;
   logic [LEN_W-1:0] words_inc;
   logic             misaligned;

   // An abort raised in the very cycle a request completes must still count,
   // so the live input is combined with the latched copy.
   assign abort_eff  = abort | abort_q;
   assign words_inc  = words_done_q + LEN_W'(1);
   assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      src_ptr_d    = src_ptr_q;
      dst_ptr_d    = dst_ptr_q;
      len_d        = len_q;
      words_done_d = words_done_q;
      buf_d        = buf_q;
      err_d        = err_q;
      abort_d      = abort_q;

      // Abort is only remembered for a running job; idle aborts are ignored.
      if ((state_q != ST_IDLE) && abort) begin
         abort_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_ptr_d    = src_addr;
               dst_ptr_d    = dst_addr;
               len_d        = len_words;
               words_done_d = '0;
               err_d        = 1'b0;
               abort_d      = 1'b0;
               // An empty job completes cleanly even if the addresses are odd.
               if (len_words == '0) begin
                  state_d = ST_FIN;
               end else if (misaligned) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_READ;
               end
            end
         end

         ST_READ: begin
            // Fault wins over ready for the same request.
            if (m_fault) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else if (m_ready) begin
               buf_d = m_rdata;
               if (abort_eff) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_WRITE;
               end
            end
         end

         ST_WRITE: begin
            if (m_fault) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else if (m_ready) begin
               words_done_d = words_inc;
               src_ptr_d    = src_ptr_q + 32'd4;
               dst_ptr_d    = dst_ptr_q + 32'd4;
               if (abort_eff) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else if (words_inc == len_q) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_READ;
               end
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         src_ptr_q    <= '0;
         dst_ptr_q    <= '0;
         len_q        <= '0;
         words_done_q <= '0;
         buf_q        <= '0;
         err_q        <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_ptr_q    <= src_ptr_d;
         dst_ptr_q    <= dst_ptr_d;
         len_q        <= len_d;
         words_done_q <= words_done_d;
         buf_q        <= buf_d;
         err_q        <= err_d;
         abort_q      <= abort_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs: decoded from registered state only, so the request fields stay
   // stable for as long as the state is held.
   //---------------------------------------------------------------------------
   always_comb begin
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_FIN);
      err        = err_q;
      words_done = words_done_q;
      m_ren      = 1'b0;
      m_wen      = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_size     = 2'b00;

      case (state_q)
         ST_READ: begin
            m_ren  = 1'b1;
            m_addr = src_ptr_q;
            m_size = WORD_SIZE;
         end
         ST_WRITE: begin
            m_wen   = 1'b1;
            m_addr  = dst_ptr_q;
            m_wdata = buf_q;
            m_size  = WORD_SIZE;
         end
         default: begin
            m_ren = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/dma_word_copy.md
Name: dma_word_copy

Overview:
- Word-granular memory-to-memory copy engine acting as **initiator** on a data-memory-style port (addr/wdata/size/ren/wen/rdata/ready/fault).
- It is the requesting end of the same port a memory slave responds on; it connects wherever a data-bus master adapter sits in front of memory or peripherals.
- Configured by a start strobe with source, destination and length. It performs read-then-write per word, one outstanding request, until complete, aborted or faulted.

Parameters:
- LEN_W, 16, width of length and progress counters (max copy = 2^LEN_W-1 words)
- WORD_SIZE, 2'b10, value driven on m_size for every request (word access)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk; 0 = reset)
- start  in  1  single-cycle strobe, accepted only when busy=0
- abort  in  1  request early termination; level or pulse, sampled every cycle
- src_addr  in  32  source byte address, latched on accepted start
- dst_addr  in  32  destination byte address, latched on accepted start
- len_words  in  LEN_W  number of 32-bit words to copy, latched on accepted start
- busy  out  1  high from cycle after accepted start until done pulse cycle (inclusive)
- done  out  1  single-cycle completion pulse
- err  out  1  set with done on misalignment/fault/abort; held until next accepted start
- words_done  out  LEN_W  count of words fully written in current/last job
- m_addr  out  32  request byte address
- m_wdata  out  32  write data
- m_size  out  2  access size, always WORD_SIZE while a request is active, 0 otherwise
- m_ren  out  1  read request
- m_wen  out  1  write request
- m_rdata  in  32  read data, valid in cycle m_ready=1 of a read
- m_ready  in  1  slave completes current request this cycle
- m_fault  in  1  slave reports error for current request

Behaviour:
- Reset (rst=0 at clk edge):
  - all outputs 0; state IDLE; internal pointers, counter and data buffer cleared.
  - Reset mid-transfer drops requests the following cycle, with no done pulse.
- States: IDLE, READ, WRITE, FIN.
- IDLE:
  - start=1 latches src/dst/len, clears err and words_done, sets busy.
  - len=0 -> FIN with err=0, no bus traffic.
  - src[1:0]!=0 or dst[1:0]!=0 -> FIN with err=1, no bus traffic.
  - Otherwise -> READ; m_ren first asserted the cycle after start.
- Request handshake:
  - m_ren/m_wen is asserted together with stable m_addr/m_size/m_wdata.
  - It is held until the cycle m_ready=1 or m_fault=1; that cycle completes it, and the request drops or changes next cycle.
  - Never m_ren and m_wen together. At most one outstanding request.
- READ: m_ren=1, m_addr=src_ptr. On m_ready: capture m_rdata into buffer, -> WRITE.
- WRITE: m_wen=1, m_addr=dst_ptr, m_wdata=buffer. On m_ready:
  - words_done+1, src_ptr+4, dst_ptr+4.
  - -> FIN if words_done+1==len, else READ.
- Pointers add modulo 2^32: 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no error.
- m_fault=1 during an active request (priority over m_ready): terminate, err=1, -> FIN. words_done excludes the faulted word.
- abort:
  - Latched while busy and cleared on accepted start.
  - Never cuts a request mid-handshake. Once the current request completes, go to FIN with err=1.
  - Abort in READ after a completed read skips the write.
- FIN: done=1 for one cycle, busy=1 this cycle, -> IDLE. busy=0 from next cycle.
- start while busy is ignored.
- Timing: with a zero-wait slave (m_ready same cycle as request), an N-word copy takes 2N+2 cycles from the start edge to the done pulse.

Test Plan:
- Reset: hold rst=0 3 cycles with start=1 -> busy/done/err/m_ren/m_wen=0, words_done=0; release -> IDLE, no requests.
- Zero-wait copy: src=0x100, dst=0x200, len=3, memory 0x100..0x108 = {0xA, 0xB, 0xC}:
  - alternating ren/wen.
  - writes 0x200=0xA, 0x204=0xB, 0x208=0xC.
  - done at cycle 8 after start, words_done=3, err=0.
- Wait states: slave delays m_ready 2 cycles per request, len=2 -> m_addr/m_ren held stable 3 cycles each, done after 14 cycles, correct data.
- Misaligned and empty jobs:
  - src=0x102, len=4 -> done one cycle after start, err=1, no m_ren/m_wen.
  - len=0, aligned -> done, err=0, no traffic.
- Fault on 2nd read of len=4 -> m_ren drops next cycle, done, err=1, words_done=1.
- Abort asserted mid-READ of word 1 with 3-cycle wait -> read completes, no write, done, err=1, words_done=1.
- Wrap: src=0xFFFF_FFF8, len=3 -> reads from 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, err=0.
